// File: rtl/game_round_fsm.sv
// game_round_fsm
//   Round sequencer for a target/torpedo game. A round loads both sprites,
//   lets the player aim while the target moves, fires the torpedo on
//   launch_key, then waits for a hit or for either sprite to leave the
//   screen. The result is held for END_CYCLES cycles before the next round.
//
// Ports
//   clk                    single clock, rising edge
//   rst                    synchronous active-high reset
//   launch_key             fire request (level, already synchronised)
//   collision              target/torpedo overlap
//   target_within_screen   target sprite still visible
//   torpedo_within_screen  torpedo sprite still visible
//   target_write_xy/dxy    target sprite load strobes
//   torpedo_write_xy/dxy   torpedo sprite load strobes
//   target_enable_update   target motion enable
//   torpedo_enable_update  torpedo motion enable
//   round_won/round_lost   result flags
//   score                  rounds won, saturating
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | one cycle after reset, everything off
// START    | load target position/velocity and stationary torpedo
// AIM      | target moving, waiting for launch_key
// LAUNCH   | one cycle: give the torpedo its velocity
// SHOOT    | both sprites moving, waiting for hit or out-of-screen
// END_WON  | hit: hold round_won for END_CYCLES cycles
// END_LOST | miss: hold round_lost for END_CYCLES cycles

module game_round_fsm #(
  parameter int END_CYCLES  = 50_000_000,
  parameter int SCORE_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   launch_key,
  input  logic                   collision,
  input  logic                   target_within_screen,
  input  logic                   torpedo_within_screen,
  output logic                   target_write_xy,
  output logic                   target_write_dxy,
  output logic                   torpedo_write_xy,
  output logic                   torpedo_write_dxy,
  output logic                   target_enable_update,
  output logic                   torpedo_enable_update,
  output logic                   round_won,
  output logic                   round_lost,
  output logic [SCORE_WIDTH-1:0] score
);

  // A one-cycle end phase still needs a 1-bit timer to keep the logic legal.
  localparam int TW = (END_CYCLES > 1) ? $clog2(END_CYCLES) : 1;
  localparam logic [TW-1:0] END_LAST = TW'(END_CYCLES - 1);
  localparam logic [SCORE_WIDTH-1:0] SCORE_MAX = {SCORE_WIDTH{1'b1}};

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    START    = 3'd1,
    AIM      = 3'd2,
    LAUNCH   = 3'd3,
    SHOOT    = 3'd4,
    END_WON  = 3'd5,
    END_LOST = 3'd6
  } state_t;

  state_t                 state_q, state_d;
  logic [TW-1:0]          end_cnt_q, end_cnt_d;
  logic [SCORE_WIDTH-1:0] score_q, score_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      end_cnt_q <= '0;
      score_q   <= '0;
    end else begin
      state_q   <= state_d;
      end_cnt_q <= end_cnt_d;
      score_q   <= score_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    end_cnt_d = end_cnt_q;
    score_d   = score_q;
    unique case (state_q)
      IDLE:   state_d = START;
      START:  state_d = AIM;
      AIM: begin
        // Losing the target takes precedence over a fire request.
        if (!target_within_screen) begin
          state_d   = END_LOST;
          end_cnt_d = '0;
        end else if (launch_key) begin
          state_d = LAUNCH;
        end
      end
      LAUNCH: state_d = SHOOT;
      SHOOT: begin
        // A hit counts even if a sprite leaves the screen in the same cycle.
        if (collision) begin
          state_d   = END_WON;
          end_cnt_d = '0;
          if (score_q != SCORE_MAX) score_d = score_q + SCORE_WIDTH'(1);
        end else if (!target_within_screen || !torpedo_within_screen) begin
          state_d   = END_LOST;
          end_cnt_d = '0;
        end
      end
      END_WON, END_LOST: begin
        if (end_cnt_q == END_LAST) begin
          state_d   = START;
          end_cnt_d = '0;
        end else begin
          end_cnt_d = end_cnt_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Moore decode: outputs depend only on the registered state.
  always_comb begin
    target_write_xy       = 1'b0;
    target_write_dxy      = 1'b0;
    torpedo_write_xy      = 1'b0;
    torpedo_write_dxy     = 1'b0;
    target_enable_update  = 1'b0;
    torpedo_enable_update = 1'b0;
    round_won             = 1'b0;
    round_lost            = 1'b0;
    unique case (state_q)
      START: begin
        target_write_xy  = 1'b1;
        target_write_dxy = 1'b1;
        torpedo_write_xy = 1'b1;
      end
      AIM: target_enable_update = 1'b1;
      LAUNCH: begin
        torpedo_write_dxy    = 1'b1;
        target_enable_update = 1'b1;
      end
      SHOOT: begin
        target_enable_update  = 1'b1;
        torpedo_enable_update = 1'b1;
      end
      END_WON:  round_won  = 1'b1;
      END_LOST: round_lost = 1'b1;
      default: ;
    endcase
  end

  assign score = score_q;

endmodule

// File: tb/tb_game_round_fsm.sv
module tb_game_round_fsm;

  localparam int END_N = 8;
  localparam int SW    = 4;

  // Output vector bit order:
  // {target_write_xy, target_write_dxy, torpedo_write_xy, torpedo_write_dxy,
  //  target_enable_update, torpedo_enable_update, round_won, round_lost}
  localparam logic [7:0] O_OFF    = 8'b0000_0000;
  localparam logic [7:0] O_LOAD   = 8'b1110_0000;
  localparam logic [7:0] O_AIM    = 8'b0000_1000;
  localparam logic [7:0] O_FIRE   = 8'b0001_1000;
  localparam logic [7:0] O_FLY    = 8'b0000_1100;
  localparam logic [7:0] O_WON    = 8'b0000_0010;
  localparam logic [7:0] O_LOST   = 8'b0000_0001;

  logic clk;
  logic rst, launch_key, collision, target_within_screen, torpedo_within_screen;
  logic target_write_xy, target_write_dxy, torpedo_write_xy, torpedo_write_dxy;
  logic target_enable_update, torpedo_enable_update, round_won, round_lost;
  logic [SW-1:0] score;
  logic [7:0] outs;

  assign outs = {target_write_xy, target_write_dxy, torpedo_write_xy, torpedo_write_dxy,
                 target_enable_update, torpedo_enable_update, round_won, round_lost};

  game_round_fsm #(.END_CYCLES(END_N), .SCORE_WIDTH(SW)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .launch_key           (launch_key),
    .collision            (collision),
    .target_within_screen (target_within_screen),
    .torpedo_within_screen(torpedo_within_screen),
    .target_write_xy      (target_write_xy),
    .target_write_dxy     (target_write_dxy),
    .torpedo_write_xy     (torpedo_write_xy),
    .torpedo_write_dxy    (torpedo_write_dxy),
    .target_enable_update (target_enable_update),
    .torpedo_enable_update(torpedo_enable_update),
    .round_won            (round_won),
    .round_lost           (round_lost),
    .score                (score)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference model: a round is a sequence of phases; the two result
  // phases are merged into one "over" phase with a remaining-cycle count.
  typedef enum int {M_IDLE, M_LOAD, M_AIM, M_FIRE, M_FLY, M_OVER} mode_t;
  mode_t m_mode = M_IDLE;
  bit    m_won  = 0;
  int    m_left = 0;
  int    m_wins = 0;

  function automatic logic [7:0] model_out();
    case (m_mode)
      M_LOAD:  return O_LOAD;
      M_AIM:   return O_AIM;
      M_FIRE:  return O_FIRE;
      M_FLY:   return O_FLY;
      M_OVER:  return m_won ? O_WON : O_LOST;
      default: return O_OFF;
    endcase
  endfunction

  task automatic model_edge(input logic r, l, c, tw, to);
    if (r) begin
      m_mode = M_IDLE;
      m_wins = 0;
    end else begin
      case (m_mode)
        M_IDLE: m_mode = M_LOAD;
        M_LOAD: m_mode = M_AIM;
        M_AIM: begin
          if (!tw) begin m_mode = M_OVER; m_won = 0; m_left = END_N; end
          else if (l) m_mode = M_FIRE;
        end
        M_FIRE: m_mode = M_FLY;
        M_FLY: begin
          if (c) begin
            m_mode = M_OVER; m_won = 1; m_left = END_N;
            m_wins = (m_wins + 1 > (1 << SW) - 1) ? (1 << SW) - 1 : m_wins + 1;
          end else if (!tw || !to) begin
            m_mode = M_OVER; m_won = 0; m_left = END_N;
          end
        end
        M_OVER: begin
          if (m_left == 1) m_mode = M_LOAD;
          else m_left--;
        end
        default: m_mode = M_IDLE;
      endcase
    end
  endtask

  // Apply inputs for one clock edge, then sample 1 time unit after it.
  task automatic step(input logic r, l, c, tw, to);
    rst = r; launch_key = l; collision = c;
    target_within_screen = tw; torpedo_within_screen = to;
    model_edge(r, l, c, tw, to);
    @(posedge clk);
    #1;
  endtask

  task automatic go_aim();
    step(1, 0, 0, 1, 1);
    step(0, 0, 0, 1, 1);
    step(0, 0, 0, 1, 1);
  endtask

  task automatic win_round();
    bit found;
    found = 0;
    step(0, 1, 0, 1, 1);
    step(0, 0, 0, 1, 1);
    step(0, 0, 1, 1, 1);
    for (int i = 0; i < 20 && !found; i++) begin
      step(0, 0, 0, 1, 1);
      if (outs == O_AIM) found = 1;
    end
    chk("win_round_back_to_aim", int'(found), 1);
  endtask

  typedef struct {
    logic r, l, c, tw, to;
    logic [7:0] exp_out;
    logic [SW-1:0] exp_score;
  } vec_t;

  function automatic vec_t mk(input logic r, l, c, tw, to,
                              input logic [7:0] eo, input logic [SW-1:0] es);
    vec_t v;
    v.r = r; v.l = l; v.c = c; v.tw = tw; v.to = to;
    v.exp_out = eo; v.exp_score = es;
    return v;
  endfunction

  vec_t tbl [10];

  initial begin
    int cnt;
    bit lost_seen;
    bit r, l, c, tw, to;

    rst = 1; launch_key = 0; collision = 0;
    target_within_screen = 1; torpedo_within_screen = 1;

    tbl[0] = mk(1, 0, 0, 1, 1, O_OFF,  4'd0); // reset -> IDLE
    tbl[1] = mk(0, 0, 0, 1, 1, O_LOAD, 4'd0); // START strobes
    tbl[2] = mk(0, 1, 0, 1, 1, O_AIM,  4'd0); // launch ignored in START
    tbl[3] = mk(0, 0, 0, 1, 1, O_AIM,  4'd0); // waiting in AIM
    tbl[4] = mk(0, 1, 0, 1, 1, O_FIRE, 4'd0); // fire
    tbl[5] = mk(0, 1, 1, 0, 0, O_FLY,  4'd0); // inputs ignored in LAUNCH
    tbl[6] = mk(0, 1, 0, 1, 1, O_FLY,  4'd0); // still flying
    tbl[7] = mk(0, 0, 1, 1, 0, O_WON,  4'd1); // hit beats out-of-screen
    tbl[8] = mk(1, 1, 1, 0, 0, O_OFF,  4'd0); // reset mid-END_WON
    tbl[9] = mk(0, 0, 0, 1, 1, O_LOAD, 4'd0); // next round starts
    for (int i = 0; i < 10; i++) begin
      step(tbl[i].r, tbl[i].l, tbl[i].c, tbl[i].tw, tbl[i].to);
      chk($sformatf("tbl%0d_outs", i), int'(outs), int'(tbl[i].exp_out));
      chk($sformatf("tbl%0d_score", i), int'(score), int'(tbl[i].exp_score));
    end

    // Held launch_key gives one launch per round.
    go_aim();
    chk("held_aim", int'(outs), int'(O_AIM));
    step(0, 1, 0, 1, 1);
    chk("held_launch", int'(outs), int'(O_FIRE));
    cnt = 1;
    for (int i = 0; i < 1000; i++) begin
      step(0, 1, 0, 1, 1);
      if (torpedo_write_dxy) cnt++;
    end
    chk("held_dxy_count", cnt, 1);
    chk("held_shoot", int'(outs), int'(O_FLY));

    // Simultaneous hit and torpedo out of screen: 8 won cycles.
    go_aim();
    step(0, 1, 0, 1, 1);
    step(0, 0, 0, 1, 1);
    step(0, 0, 1, 1, 0);
    chk("won_entry", int'(outs), int'(O_WON));
    chk("won_score", int'(score), 1);
    cnt = 1;
    lost_seen = 0;
    for (int i = 0; i < 20; i++) begin
      step(0, 0, 0, 1, 1);
      if (round_lost) lost_seen = 1;
      if (!round_won) break;
      cnt++;
    end
    chk("won_cycles", cnt, END_N);
    chk("won_no_lost", int'(lost_seen), 0);
    chk("won_then_start", int'(outs), int'(O_LOAD));

    // Target leaves screen in AIM: 8 lost cycles, score kept.
    step(0, 0, 0, 1, 1);
    chk("lost_aim", int'(outs), int'(O_AIM));
    step(0, 1, 0, 0, 1);
    chk("lost_entry", int'(outs), int'(O_LOST));
    cnt = 1;
    for (int i = 0; i < 20; i++) begin
      step(0, 0, 0, 1, 1);
      if (!round_lost) break;
      cnt++;
    end
    chk("lost_cycles", cnt, END_N);
    chk("lost_score", int'(score), 1);
    chk("lost_then_start", int'(outs), int'(O_LOAD));

    // Score saturation over 17 wins.
    go_aim();
    for (int i = 0; i < 17; i++) begin
      win_round();
      if (i == 14) chk("sat_score_15", int'(score), 15);
    end
    chk("sat_score_17", int'(score), 15);

    // Reset mid-END_WON with score 3.
    go_aim();
    for (int i = 0; i < 3; i++) win_round();
    step(0, 1, 0, 1, 1);
    step(0, 0, 0, 1, 1);
    step(0, 0, 1, 1, 1);
    step(0, 0, 0, 1, 1);
    chk("midend_won", int'(outs), int'(O_WON));
    chk("midend_score", int'(score), 4);
    step(1, 0, 0, 1, 1);
    chk("midend_rst_outs", int'(outs), int'(O_OFF));
    chk("midend_rst_score", int'(score), 0);
    step(0, 0, 0, 1, 1);
    chk("midend_restart", int'(outs), int'(O_LOAD));

    // Randomised run against the reference model.
    step(1, 0, 0, 1, 1);
    for (int i = 0; i < 3000; i++) begin
      r  = ($urandom_range(0, 199) == 0);
      l  = ($urandom_range(0, 3) == 0);
      c  = ($urandom_range(0, 11) == 0);
      tw = ($urandom_range(0, 24) != 0);
      to = ($urandom_range(0, 24) != 0);
      step(r, l, c, tw, to);
      chk($sformatf("rand%0d_outs", i), int'(outs), int'(model_out()));
      chk($sformatf("rand%0d_score", i), int'(score), m_wins);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
